// File: rtl/fir_sample_loader.sv
// Streams samples over valid/ready into memory port B, then kicks the FIR filter and waits for done.
// Optional running checksum enabled by defining FIR_LOADER_CHECKSUM_EN.
module fir_sample_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_count,
  input  logic              load_go,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we_b,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [DATA_W-1:0] mem_data_in_b,
  output logic              fir_start,
  input  logic              fir_done,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W-1:0] loaded_count,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {StIdle, StLoad, StKick, StWaitDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_inc;
  logic              handshake;
  logic              go_accept;

  assign s_ready   = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign handshake = s_valid && s_ready;
  assign go_accept = (state_q == StIdle) && load_go && (cfg_count != '0);
  assign count_inc = loaded_count + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      base_q        <= '0;
      count_q       <= '0;
      loaded_count  <= '0;
      mem_we_b      <= 1'b0;
      mem_addr_b    <= '0;
      mem_data_in_b <= '0;
      fir_start     <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      mem_we_b  <= 1'b0;
      fir_start <= 1'b0;
      load_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go_accept) begin
            base_q       <= cfg_base_addr;
            count_q      <= cfg_count;
            loaded_count <= '0;
            state_q      <= StLoad;
          end else if (load_go) begin
            // Zero-length request completes immediately without touching memory or the filter
            load_done <= 1'b1;
          end
        end
        StLoad: begin
          if (handshake) begin
            mem_we_b      <= 1'b1;
            mem_addr_b    <= base_q + loaded_count;
            mem_data_in_b <= s_data;
            loaded_count  <= count_inc;
            if (count_inc == count_q) begin
              state_q <= StKick;
            end
          end
        end
        StKick: begin
          fir_start <= 1'b1;
          state_q   <= StWaitDone;
        end
        StWaitDone: begin
          if (fir_done) begin
            load_done <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FIR_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (go_accept) begin
      checksum_q <= '0;
    end else if (handshake) begin
      checksum_q <= checksum_q + 16'($signed(s_data));
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_fir_sample_loader.sv
// Directed self-checking bench for fir_sample_loader; checksum checks follow FIR_LOADER_CHECKSUM_EN.
module tb_fir_sample_loader;

  logic        clk;
  logic        rst;
  logic [9:0]  cfg_base_addr;
  logic [9:0]  cfg_count;
  logic        load_go;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we_b;
  logic [9:0]  mem_addr_b;
  logic [7:0]  mem_data_in_b;
  logic        fir_start;
  logic        fir_done;
  logic        busy;
  logic        load_done;
  logic [9:0]  loaded_count;
  logic [15:0] checksum;

  int total;
  int bad;
  int start_cnt;
  int we_cnt;

  fir_sample_loader #(
    .ADDR_W(10),
    .DATA_W(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_base_addr(cfg_base_addr),
    .cfg_count    (cfg_count),
    .load_go      (load_go),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .mem_we_b     (mem_we_b),
    .mem_addr_b   (mem_addr_b),
    .mem_data_in_b(mem_data_in_b),
    .fir_start    (fir_start),
    .fir_done     (fir_done),
    .busy         (busy),
    .load_done    (load_done),
    .loaded_count (loaded_count),
    .checksum     (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fir_start) start_cnt <= start_cnt + 1;
    if (mem_we_b) we_cnt <= we_cnt + 1;
  end

  // Advance one edge; outputs are then read 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({s_ready, mem_we_b, fir_start, busy, load_done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000", {s_ready, mem_we_b, fir_start, busy, load_done});
    end
    total++;
    if (mem_addr_b !== 10'd0 || mem_data_in_b !== 8'd0 || loaded_count !== 10'd0
        || checksum !== 16'd0) begin
      bad++;
      $display("FAIL reset_values got addr=%0d data=%0d cnt=%0d sum=%h want all 0",
               mem_addr_b, mem_data_in_b, loaded_count, checksum);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    logic [7:0] samples [5];
    int starts0;
    samples[0] = 8'd0; samples[1] = 8'd10; samples[2] = 8'd19;
    samples[3] = 8'd27; samples[4] = 8'd33;
    starts0 = start_cnt;
    cfg_base_addr = 10'd0;
    cfg_count = 10'd5;
    load_go = 1'b1;
    tick();
    load_go = 1'b0;
    total++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL burst_go got busy=%b ready=%b want 1 1", busy, s_ready);
    end
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = samples[i];
      tick();
      total++;
      if (mem_we_b !== 1'b1 || mem_addr_b !== 10'(i) || mem_data_in_b !== samples[i]) begin
        bad++;
        $display("FAIL burst_write%0d got we=%b addr=%0d data=%0d want 1 %0d %0d",
                 i, mem_we_b, mem_addr_b, mem_data_in_b, i, samples[i]);
      end
    end
    s_valid = 1'b0;
    total++;
    if (s_ready !== 1'b0 || loaded_count !== 10'd5 || fir_start !== 1'b0) begin
      bad++;
      $display("FAIL burst_last got ready=%b cnt=%0d start=%b want 0 5 0",
               s_ready, loaded_count, fir_start);
    end
    tick();
    fir_done = 1'b1;
    total++;
    if (fir_start !== 1'b1 || mem_we_b !== 1'b0) begin
      bad++;
      $display("FAIL burst_kick got start=%b we=%b want 1 0", fir_start, mem_we_b);
    end
    tick();
    fir_done = 1'b0;
    total++;
    if (load_done !== 1'b1 || busy !== 1'b0 || fir_start !== 1'b0) begin
      bad++;
      $display("FAIL burst_done got done=%b busy=%b start=%b want 1 0 0",
               load_done, busy, fir_start);
    end
`ifdef FIR_LOADER_CHECKSUM_EN
    total++;
    if (checksum !== 16'd89) begin
      bad++;
      $display("FAIL burst_checksum got=%h want=0059", checksum);
    end
`endif
    tick();
    total++;
    if (load_done !== 1'b0 || start_cnt - starts0 != 1 || loaded_count !== 10'd5) begin
      bad++;
      $display("FAIL burst_after got done=%b starts=%0d cnt=%0d want 0 1 5",
               load_done, start_cnt - starts0, loaded_count);
    end
  endtask

  task automatic test_wrap_backpressure();
    logic [7:0] samples [4];
    logic [9:0] addrs [4];
    samples[0] = 8'd64; samples[1] = 8'hC0; samples[2] = 8'd127; samples[3] = 8'hFF;
    addrs[0] = 10'd1022; addrs[1] = 10'd1023; addrs[2] = 10'd0; addrs[3] = 10'd1;
    cfg_base_addr = 10'd1022;
    cfg_count = 10'd4;
    load_go = 1'b1;
    tick();
    load_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data = samples[i];
      tick();
      total++;
      if (mem_we_b !== 1'b1 || mem_addr_b !== addrs[i] || mem_data_in_b !== samples[i]) begin
        bad++;
        $display("FAIL wrap_write%0d got we=%b addr=%0d data=%h want 1 %0d %h",
                 i, mem_we_b, mem_addr_b, mem_data_in_b, addrs[i], samples[i]);
      end
      s_valid = 1'b0;
      s_data = 8'h55;
      // Final handshake leaves KICK; hold done high there to show it is ignored.
      if (i == 3) fir_done = 1'b1;
      tick();
      if (i < 3) begin
        total++;
        if (mem_we_b !== 1'b0 || loaded_count !== 10'(i + 1)) begin
          bad++;
          $display("FAIL wrap_idle%0d got we=%b cnt=%0d want 0 %0d",
                   i, mem_we_b, loaded_count, i + 1);
        end
      end
    end
    total++;
    if (fir_start !== 1'b1 || load_done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL wrap_kick_ignores_done got start=%b done=%b busy=%b want 1 0 1",
               fir_start, load_done, busy);
    end
    tick();
    fir_done = 1'b0;
    total++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wrap_done got done=%b busy=%b want 1 0", load_done, busy);
    end
`ifdef FIR_LOADER_CHECKSUM_EN
    total++;
    if (checksum !== 16'h007E) begin
      bad++;
      $display("FAIL wrap_checksum got=%h want=007e", checksum);
    end
`else
    total++;
    if (checksum !== 16'h0000) begin
      bad++;
      $display("FAIL checksum_disabled got=%h want=0000", checksum);
    end
`endif
    tick();
  endtask

  task automatic test_zero_and_ignored();
    int starts0;
    int we0;
    starts0 = start_cnt;
    we0 = we_cnt;
    cfg_count = 10'd0;
    load_go = 1'b1;
    tick();
    load_go = 1'b0;
    total++;
    if (load_done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_count got done=%b busy=%b ready=%b want 1 0 0",
               load_done, busy, s_ready);
    end
    tick();
    total++;
    if (load_done !== 1'b0 || start_cnt != starts0 || we_cnt != we0) begin
      bad++;
      $display("FAIL zero_side_effects got done=%b starts=%0d writes=%0d want 0 0 0",
               load_done, start_cnt - starts0, we_cnt - we0);
    end
    cfg_base_addr = 10'd100;
    cfg_count = 10'd2;
    load_go = 1'b1;
    tick();
    // load_go stays high and cfg changes while busy: both must be ignored.
    cfg_base_addr = 10'd500;
    cfg_count = 10'd7;
    s_valid = 1'b1;
    s_data = 8'd1;
    tick();
    s_data = 8'd2;
    tick();
    s_valid = 1'b0;
    total++;
    if (mem_addr_b !== 10'd101 || s_ready !== 1'b0 || loaded_count !== 10'd2) begin
      bad++;
      $display("FAIL ignored_go_load got addr=%0d ready=%b cnt=%0d want 101 0 2",
               mem_addr_b, s_ready, loaded_count);
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b1 || loaded_count !== 10'd2 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL ignored_go_wait got busy=%b cnt=%0d ready=%b want 1 2 0",
               busy, loaded_count, s_ready);
    end
    load_go = 1'b0;
    fir_done = 1'b1;
    tick();
    fir_done = 1'b0;
    total++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignored_go_done got done=%b busy=%b want 1 0", load_done, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int starts0;
    starts0 = start_cnt;
    cfg_base_addr = 10'd200;
    cfg_count = 10'd8;
    load_go = 1'b1;
    tick();
    load_go = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'(i + 5);
      tick();
    end
    total++;
    if (mem_addr_b !== 10'd202 || loaded_count !== 10'd3) begin
      bad++;
      $display("FAIL midreset_pre got addr=%0d cnt=%0d want 202 3", mem_addr_b, loaded_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (s_ready !== 1'b0 || busy !== 1'b0 || loaded_count !== 10'd0 || mem_we_b !== 1'b0) begin
      bad++;
      $display("FAIL midreset_abort got ready=%b busy=%b cnt=%0d we=%b want 0 0 0 0",
               s_ready, busy, loaded_count, mem_we_b);
    end
    s_valid = 1'b0;
    fir_done = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    fir_done = 1'b0;
    total++;
    if (start_cnt != starts0 || load_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_quiet got starts=%0d done=%b busy=%b want 0 0 0",
               start_cnt - starts0, load_done, busy);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    start_cnt = 0;
    we_cnt = 0;
    rst = 1'b1;
    cfg_base_addr = '0;
    cfg_count = '0;
    load_go = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    fir_done = 1'b0;
    test_reset();
    test_burst();
    test_wrap_backpressure();
    test_zero_and_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_sample_loader.md
# fir_sample_loader

Upstream feeder for the FIR filter top. It accepts a stream of 8-bit signed samples over a valid/ready handshake and writes them into the shared sample memory through write port B at a configured base address. Once the configured number of samples is stored, it issues a one-cycle start pulse to the filter and waits for the filter's done. This replaces the testbench practice of forcing memory signals with a synthesizable load path.

## Interface
Parameters:
- ADDR_W, 10, memory address width and sample-count width
- DATA_W, 8, sample width

Ports:
- clk  in  1  system clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- cfg_base_addr  in  ADDR_W  first memory address written; sampled on accepted load_go
- cfg_count  in  ADDR_W  number of samples to load; sampled on accepted load_go
- load_go  in  1  level-sampled request to begin a load; honoured only in IDLE
- s_valid  in  1  upstream sample valid
- s_data  in  DATA_W  upstream sample
- s_ready  out  1  loader can accept a sample
- mem_we_b  out  1  memory port B write enable (registered)
- mem_addr_b  out  ADDR_W  memory port B address (registered)
- mem_data_in_b  out  DATA_W  memory port B write data (registered)
- fir_start  out  1  one-cycle start pulse to the filter
- fir_done  in  1  filter completion level or pulse
- busy  out  1  high in any state except IDLE
- load_done  out  1  one-cycle pulse at end of a transaction
- loaded_count  out  ADDR_W  samples written in the current or last transaction
- checksum  out  16  running sum of samples; present only with the macro

## Operation
- States: IDLE, LOAD, KICK, WAIT_DONE.
- IDLE:
  - load_go=1 with cfg_count≠0: latch the base address and count, clear loaded_count and checksum, go to LOAD.
  - load_go=1 with cfg_count=0: pulse load_done, issue no write and no fir_start, stay in IDLE.
- LOAD:
  - s_ready=1, decoded from the state only.
  - Each handshake (s_valid & s_ready) registers mem_we_b=1, mem_addr_b = base + loaded_count (mod 2^ADDR_W, wraps 1023→0), mem_data_in_b = s_data, and increments loaded_count.
  - The handshake that makes loaded_count equal the latched count moves the FSM to KICK.
- KICK: fir_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: the first cycle with fir_done=1 pulses load_done and returns to IDLE. fir_done seen during KICK is ignored.
- load_go outside IDLE is ignored. Changes to cfg_* after latching have no effect.
- s_valid without s_ready performs no write. s_data is don't-care.
- Checksum arithmetic: 16-bit sign-extended accumulate, wrap on overflow.

## Timing
- Reset values: s_ready=0, mem_we_b=0, mem_addr_b=0, mem_data_in_b=0, fir_start=0, busy=0, load_done=0, loaded_count=0, checksum=0. State is IDLE.
- Reset asserted mid-transaction aborts it at the next edge. Writes already issued stay in memory. No fir_start or load_done pulse follows the abort.
- load_go sampled at edge N: busy and s_ready are high after edge N.
- Handshake at edge N: write signals are valid in the cycle after edge N, and memory commits at edge N+1. mem_we_b is low in every cycle without a preceding handshake.
- Final handshake at edge N: s_ready is low after edge N, and fir_start is high from edge N+1 to N+2.
- Throughput: one sample per cycle. Minimum transaction length is count + 2 cycles plus filter time.

## Configuration
- FIR_LOADER_CHECKSUM_EN defined: the checksum port and accumulator are present. The value is stable from load_done until the next accepted load_go.
- FIR_LOADER_CHECKSUM_EN undefined: checksum is driven constant 0 and no accumulator is synthesized.

## Test plan
- Reset sequence: hold rst for 2 cycles → every output equals its reset value, state is IDLE.
- Burst load: base=0, count=5, s_valid held high, samples 0,10,19,27,33 → addresses 0..4 written in consecutive cycles, exactly one fir_start one cycle after the last write, load_done on fir_done, loaded_count=5.
- Backpressure and wraparound: base=1022, count=4, s_valid toggling 1/0 → writes land at 1022,1023,0,1 only on valid cycles; no write on idle cycles.
- Zero count and ignored requests: cfg_count=0 → load_done pulse, no mem_we_b, no fir_start. load_go pulsed during LOAD and WAIT_DONE → no effect.
- Reset mid-operation: rst asserted after the 3rd of 8 samples → s_ready=0 next cycle, fir_start never pulses, loaded_count=0.
- Checksum (macro defined): samples 64,-64,127,-1 → checksum 0x007E. Macro undefined → checksum=0 throughout.
